// File: rtl/bool_sweep_gen.sv
// Purpose: sweeps every N_IN-bit input vector (binary or Gray order) into a function under test and scores its response against TRUTH.
// Latency: done rises 2^N_IN*HOLD edges after the start-accept edge (the accept edge itself counting as edge 1 of 2^N_IN*HOLD+1).
// Backpressure: none; start is only honoured in IDLE or DONE and ignored while a sweep is running.
module bool_sweep_gen #(
    parameter int                     N_IN  = 3,
    parameter int                     HOLD  = 5,
    parameter logic [(1<<N_IN)-1:0]   TRUTH = 8'b1110_1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              func_out,
    output logic [N_IN-1:0]   vec_out,
    output logic              vec_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     mismatch_cnt,
    output logic [N_IN-1:0]   first_fail,
    output logic              first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [N_IN-1:0] LAST_IDX  = '1;
    localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);

    state_t            state;
    logic              mode_q;
    logic [N_IN-1:0]   index;
    logic [7:0]        hold_cnt;

    logic              sample;
    logic              miss;
    logic [N_IN:0]     mm_next;

    // Index to applied vector: straight count or reflected Gray code.
    function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] idx, input logic gray);
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

    // Sample-cycle detection and the mismatch count including this cycle's result.
    always_comb begin
        sample  = (state == APPLY) && (hold_cnt == HOLD_LAST);
        miss    = sample && (func_out != TRUTH[vec_out]);
        mm_next = mismatch_cnt + (N_IN+1)'(miss);
    end

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            mode_q           <= 1'b0;
            index            <= '0;
            hold_cnt         <= '0;
            vec_out          <= '0;
            vec_valid        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= APPLY;
                        mode_q           <= mode;
                        index            <= '0;
                        hold_cnt         <= '0;
                        vec_out          <= '0;
                        vec_valid        <= 1'b1;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        mismatch_cnt     <= '0;
                        first_fail       <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                APPLY: begin
                    if (sample) begin
                        mismatch_cnt <= mm_next;
                        if (miss && !first_fail_valid) begin
                            first_fail       <= vec_out;
                            first_fail_valid <= 1'b1;
                        end
                        hold_cnt <= '0;
                        if (index == LAST_IDX) begin
                            // Last vector scored: stop here, vec_out keeps the final vector.
                            state     <= DONE;
                            vec_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (mm_next == '0);
                        end else begin
                            index   <= index + N_IN'(1);
                            vec_out <= map_vec(index + N_IN'(1), mode_q);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bool_sweep_gen.sv
// Purpose: randomized and directed checks of bool_sweep_gen against a sweep-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_bool_sweep_gen;

    localparam logic [7:0] TRUTH0 = 8'b1110_1000;  // 3-input majority
    localparam logic [3:0] TRUTH1 = 4'b0110;       // 2-input XOR

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Default-parameter instance
    logic       start0 = 1'b0, mode0 = 1'b0, func0;
    logic [2:0] vec0, ff0;
    logic       vv0, busy0, done0, pass0, ffv0;
    logic [3:0] mm0;
    logic [7:0] resp0 = 8'h00;

    // N_IN=2, HOLD=1 instance
    logic       start1 = 1'b0, mode1 = 1'b0, func1;
    logic [1:0] vec1, ff1;
    logic       vv1, busy1, done1, pass1, ffv1;
    logic [2:0] mm1;
    logic [3:0] resp1 = 4'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign func0 = resp0[vec0];
    assign func1 = resp1[vec1];

    bool_sweep_gen dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0), .func_out(func0),
        .vec_out(vec0), .vec_valid(vv0), .busy(busy0), .done(done0), .pass(pass0),
        .mismatch_cnt(mm0), .first_fail(ff0), .first_fail_valid(ffv0)
    );

    bool_sweep_gen #(.N_IN(2), .HOLD(1), .TRUTH(TRUTH1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .func_out(func1),
        .vec_out(vec1), .vec_valid(vv1), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_cnt(mm1), .first_fail(ff1), .first_fail_valid(ffv1)
    );

    // k-th vector of a sweep in the given order
    function automatic int exp_vec(input int k, input logic gray);
        return gray ? (k ^ (k >> 1)) : k;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Full sweep on dut0 (N_IN=3, HOLD=5); poke_at >= 0 pulses start into the edge after that count
    task automatic run_sweep0(input string name, input logic m, input logic [7:0] tbl, input int poke_at);
        int exp_mm = 0, exp_ff = 0, exp_ffv = 0, edges, v, bad_seq;
        for (int k = 0; k < 8; k++) begin
            v = exp_vec(k, m);
            if (tbl[v] != TRUTH0[v]) begin
                exp_mm++;
                if (exp_ffv == 0) begin exp_ff = v; exp_ffv = 1; end
            end
        end
        resp0 = tbl;
        @(negedge clk);
        mode0 = m; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        mode0 = ~m;  // must have been latched already
        edges = 1;
        chk({name, " accept busy"}, busy0, 1);
        chk({name, " accept done"}, done0, 0);
        chk({name, " accept mm"}, mm0, 0);
        chk({name, " accept ffv"}, ffv0, 0);
        bad_seq = 0;
        while (done0 !== 1'b1 && edges < 200) begin
            if (vec0 !== 3'(exp_vec((edges - 1) / 5, m)) || vv0 !== 1'b1 || busy0 !== 1'b1 || pass0 !== 1'b0) begin
                if (bad_seq == 0)
                    $display("FAIL %s seq edge %0d: got vec=%0d vv=%0d busy=%0d pass=%0d expected vec=%0d vv=1 busy=1 pass=0",
                             name, edges, vec0, vv0, busy0, pass0, exp_vec((edges - 1) / 5, m));
                bad_seq++;
            end
            if (edges == poke_at) start0 = 1'b1;
            @(posedge clk); #1;
            start0 = 1'b0;
            edges++;
        end
        checks++;
        if (bad_seq != 0) errors++;
        chk({name, " latency"}, edges, 41);
        chk({name, " busy"}, busy0, 0);
        chk({name, " vec_valid"}, vv0, 0);
        chk({name, " vec_out hold"}, vec0, exp_vec(7, m));
        chk({name, " mismatch_cnt"}, mm0, exp_mm);
        chk({name, " first_fail_valid"}, ffv0, exp_ffv);
        chk({name, " first_fail"}, ff0, exp_ff);
        chk({name, " pass"}, pass0, (exp_mm == 0) ? 1 : 0);
        if (poke_at >= 0) begin
            @(posedge clk); #1;
            chk({name, " stays done"}, done0, 1);
            chk({name, " stays idle"}, busy0, 0);
        end
    endtask

    // Full sweep on dut1 (N_IN=2, HOLD=1)
    task automatic run_sweep1(input string name, input logic m, input logic [3:0] tbl);
        int exp_mm = 0, exp_ff = 0, exp_ffv = 0, edges, v;
        for (int k = 0; k < 4; k++) begin
            v = exp_vec(k, m);
            if (tbl[v] != TRUTH1[v]) begin
                exp_mm++;
                if (exp_ffv == 0) begin exp_ff = v; exp_ffv = 1; end
            end
        end
        resp1 = tbl;
        @(negedge clk);
        mode1 = m; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        edges = 1;
        while (done1 !== 1'b1 && edges < 50) begin
            chk({name, " vec"}, vec1, exp_vec(edges - 1, m));
            @(posedge clk); #1;
            edges++;
        end
        chk({name, " latency"}, edges, 5);
        chk({name, " mismatch_cnt"}, mm1, exp_mm);
        chk({name, " first_fail"}, ff1, exp_ff);
        chk({name, " first_fail_valid"}, ffv1, exp_ffv);
        chk({name, " pass"}, pass1, (exp_mm == 0) ? 1 : 0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        chk("rst vec_out", vec0, 0);
        chk("rst busy", busy0, 0);
        chk("rst done", done0, 0);
        chk("rst pass", pass0, 0);
        chk("rst mm", mm0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle after rst", busy0 | vv0 | done1 | busy1, 0);
    endtask

    task automatic test_directed;
        run_sweep0("maj", 1'b0, TRUTH0, -1);
        run_sweep0("tied0", 1'b0, 8'h00, -1);
        run_sweep0("gray_tied1", 1'b1, 8'hFF, -1);
    endtask

    task automatic test_start_ignored;
        run_sweep0("poke_mid", 1'b0, 8'h5A, 13);
        run_sweep0("poke_last", 1'b1, TRUTH0, 40);
    endtask

    task automatic test_back_to_back;
        // Starting from DONE with mismatches still reported must clear them
        run_sweep0("b2b_a", 1'b0, 8'h00, -1);
        run_sweep0("b2b_b", 1'b0, TRUTH0, -1);
    endtask

    task automatic test_async_reset;
        resp0 = TRUTH0;
        @(negedge clk);
        mode0 = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (21) @(posedge clk);  // now in vector 4
        #2;
        chk("mid vec before rst", vec0, 4);
        rst = 1'b1;
        #1;
        chk("async vec_out", vec0, 0);
        chk("async busy", busy0, 0);
        chk("async vec_valid", vv0, 0);
        chk("async done", done0, 0);
        chk("async mm", mm0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("no activity after rst", busy0 | vv0 | done0, 0);
        run_sweep0("post_rst", 1'b0, TRUTH0, -1);
    endtask

    task automatic test_small;
        run_sweep1("xor", 1'b0, TRUTH1);
        run_sweep1("xor_gray", 1'b1, TRUTH1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            run_sweep0("rand3", 1'($urandom_range(0, 1)), 8'($urandom), (i == 2) ? int'($urandom_range(2, 39)) : -1);
            run_sweep1("rand2", 1'($urandom_range(0, 1)), 4'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        test_small();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bool_sweep_gen.md
BOOL_SWEEP_GEN -- requirements
Module: bool_sweep_gen

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, meaning the number of Boolean inputs swept (legal range 1..8).
REQ-002 The block SHALL have parameter HOLD, default 5, meaning the number of clock cycles each vector is held (legal range 1..255).
REQ-003 The block SHALL have parameter TRUTH, default 8'b1110_1000, meaning the expected output for each vector value v, with TRUTH width 2^N_IN and bit v = expected result.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, width 1: rising-edge clock.
REQ-006 The block SHALL have port rst, input, width 1: asynchronous active-high reset.
REQ-007 The block SHALL have port start, input, width 1: single-cycle sweep request.
REQ-008 The block SHALL have port mode, input, width 1: sweep order, 0 = binary count, 1 = Gray code; latched on accepted start.
REQ-009 The block SHALL have port func_out, input, width 1: response of the function under test.
REQ-010 The block SHALL have port vec_out, output, width N_IN: applied input vector, bit0 = first operand.
REQ-011 The block SHALL have port vec_valid, output, width 1: vec_out is being driven as part of a sweep.
REQ-012 The block SHALL have port busy, output, width 1: sweep in progress.
REQ-013 The block SHALL have port done, output, width 1: sweep complete; held until the next accepted start or reset.
REQ-014 The block SHALL have port pass, output, width 1: 1 when done and mismatch_cnt == 0.
REQ-015 The block SHALL have port mismatch_cnt, output, width N_IN+1: number of failing vectors.
REQ-016 The block SHALL have port first_fail, output, width N_IN: vector value of the first mismatch.
REQ-017 The block SHALL have port first_fail_valid, output, width 1: first_fail holds a captured value.

Function
REQ-018 The FSM SHALL have states IDLE, APPLY and DONE; every register SHALL update on the rising edge of clk.
REQ-019 In IDLE or DONE, start=1 SHALL cause these updates on the next edge:
- state -> APPLY; latch mode.
- index = 0, hold_cnt = 0.
- clear mismatch_cnt, first_fail and first_fail_valid; done = 0.
REQ-020 In APPLY, start SHALL be ignored.
REQ-021 In APPLY, vec_out SHALL be index when the latched mode = 0, and index ^ (index >> 1) when the latched mode = 1.
REQ-022 In APPLY, vec_valid = 1 and busy = 1.
REQ-023 hold_cnt SHALL count 0..HOLD-1 for each vector.
REQ-024 When hold_cnt == HOLD-1, func_out SHALL be sampled and compared with TRUTH[vec_out]; this is the sample cycle.
REQ-025 On a sample-cycle mismatch, mismatch_cnt SHALL increment by 1; no saturation is required, since the maximum value 2^N_IN fits.
REQ-026 If first_fail_valid = 0 on a mismatch, first_fail <= vec_out and first_fail_valid <= 1; later mismatches SHALL NOT change first_fail.
REQ-027 After the sample cycle, index SHALL increment and hold_cnt SHALL return to 0.
REQ-028 If index == 2^N_IN-1 at the sample cycle, state -> DONE instead of incrementing; index SHALL NOT wrap into a second pass.
REQ-029 In DONE, done = 1, busy = 0, vec_valid = 0, and vec_out SHALL hold the last applied vector.
REQ-030 pass SHALL be a registered output: 1 only in DONE with mismatch_cnt == 0, otherwise 0.
REQ-031 With HOLD = 1, every APPLY cycle SHALL be a sample cycle.
REQ-032 Sweep latency from the start-accept edge to done = 1 SHALL be 2^N_IN * HOLD + 1 cycles.
REQ-033 A start asserted in the same cycle as the final sample SHALL be ignored; the FSM enters DONE.

Reset
REQ-034 rst = 1 SHALL immediately, without waiting for clk, force:
- state = IDLE.
- index, hold_cnt, vec_out, vec_valid, busy, done and pass = 0.
- mismatch_cnt, first_fail and first_fail_valid = 0.
- latched mode = 0.
REQ-035 Reset SHALL be honoured in every state, including mid-sweep, and SHALL abort the sweep with no partial results retained.
REQ-036 After rst deasserts, the block SHALL remain in IDLE until a start is accepted.

Verification
REQ-037 Defaults, mode=0, func_out = 3-input majority of vec_out -> vec_out steps 0..7 for 5 cycles each; done at 41 cycles after start; pass=1, mismatch_cnt=0.
REQ-038 Defaults, mode=0, func_out tied 0 -> mismatch_cnt=4, first_fail=3'b011, first_fail_valid=1, pass=0.
REQ-039 Defaults, mode=1, func_out tied 1 -> vec_out order 0,1,3,2,6,7,5,4; mismatch_cnt=4, first_fail=3'b000.
REQ-040 rst pulsed asynchronously, mid-edge, during vector 4 -> all outputs 0 immediately; no activity until a new start; the following sweep completes normally with pass=1.
REQ-041 start pulsed during APPLY -> no effect on index or timing; start in DONE -> counters cleared, new sweep begins.
REQ-042 N_IN=2, HOLD=1, TRUTH=4'b0110, func_out = XOR -> done 5 cycles after start, pass=1.
